program_loader: RTL
===================

Name: program_loader

Overview:
- Source-side companion of the CPU's Load/data_in instruction-load interface.
- Accepts a program byte stream from a host over a valid/ready handshake and buffers it in a local program buffer.
- Replays the buffer to the CPU as a contiguous burst of Load-qualified bytes, then flags completion so the CPU can run.
- Sits between the host/testbench byte source and the CPU's Load and data_in inputs.

Parameters:
DEPTH, 32, program buffer entries; matches the 5-bit program counter space; power of two, 2..256
PAD_TO_FULL, 1, 1 = stream pads with PAD_BYTE up to DEPTH bytes; 0 = stream only the received bytes
PAD_BYTE, 8'h00, filler byte (HALT opcode 3'b000, address 0)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  1-cycle request to begin a load session; ignored unless in IDLE or DONE
host_valid  input  1  host byte valid
host_data  input  8  program byte {opcode[7:5], addr[4:0]}
host_last  input  1  marks the final program byte; qualified by host_valid
host_ready  output  1  loader accepts host_data this cycle
load_out  output  1  to CPU Load; high for exactly the streamed-byte count
data_out  output  8  to CPU data_in; valid when load_out=1
busy  output  1  high in FILL or STREAM
done  output  1  high in DONE; held until start or reset
byte_count  output  clog2(DEPTH)+1  bytes received in the current session

Behaviour:
- Reset values: host_ready=0, load_out=0, data_out=8'h00, busy=0, done=0, byte_count=0, state=IDLE. Buffer contents are not reset.
- Reset mid-session aborts immediately. load_out drops on the next edge. No partial stream resumes.
- FSM states: IDLE, FILL, STREAM, DONE.
- IDLE:
  - start=1 -> FILL.
  - Clears wr_ptr, rd_ptr and byte_count.
- DONE:
  - start=1 -> FILL, with the same clearing as IDLE.
  - done falls on the same edge.
- FILL:
  - host_ready = (state==FILL) && (wr_ptr<DEPTH). It is combinational from registered state.
  - A transfer occurs when host_valid && host_ready. On a transfer, buf[wr_ptr] <= host_data, wr_ptr++ and byte_count++.
  - A transfer with host_last=1 -> STREAM.
  - A transfer that makes wr_ptr==DEPTH -> STREAM, regardless of host_last. Extra host bytes are refused (host_ready=0).
  - host_last without host_valid is ignored.
- STREAM:
  - N = PAD_TO_FULL ? DEPTH : byte_count.
  - Each cycle: data_out <= (rd_ptr<byte_count) ? buf[rd_ptr] : PAD_BYTE; load_out <= 1; rd_ptr++.
  - When rd_ptr==N-1 is issued -> DONE.
  - Outputs are registered. load_out is high for exactly N consecutive cycles, starting 1 cycle after the STREAM entry edge.
  - Byte k appears on data_out in the k-th load_out cycle. Order is address 0 first, no gaps.
  - In the cycle after the last byte: load_out=0 and data_out holds the last value.
- DONE:
  - done=1, busy=0, host_ready=0.
  - byte_count is held for inspection.
- start during FILL or STREAM is ignored.
- host_valid outside FILL is ignored and host_ready=0. No buffer write occurs.
- Width rules: wr_ptr, rd_ptr and byte_count are clog2(DEPTH)+1 bits, so the value DEPTH is representable. No wrap-around. Compares are unsigned.
- Minimum session: a single byte with host_last.
  - PAD_TO_FULL=0: exactly 1 load cycle.
  - PAD_TO_FULL=1: DEPTH load cycles.
- Latency:
  - start edge to host_ready=1: 1 cycle.
  - Last accepted byte edge to first load_out=1: 2 edges (FILL->STREAM edge, then output register edge).

Decomposition:
- Shared package:
  - loader state enum (IDLE, FILL, STREAM, DONE)
  - opcode width 3 and address width 5 constants
  - HALT opcode constant (3'b000), used to form the PAD_BYTE default
- One sub-module is natural: program_buffer.
  - DEPTH x 8 array.
  - Synchronous write port.
  - Asynchronous read port indexed by rd_ptr.
- The FSM and counters stay in program_loader.

Test Plan:
- Reset and idle (reset high 2 cycles, then idle 5 cycles) -> all outputs 0, host_ready=0 throughout.
- PAD_TO_FULL=0:
  - Stimulus: start, then bytes 8'hA3, 8'h41, 8'hE7 with last on 8'hE7, host_valid held high.
  - Response: load_out high exactly 3 cycles carrying A3, 41, E7 in order; done=1 afterward; byte_count=3.
- PAD_TO_FULL=1, full buffer:
  - Stimulus: start, 32 bytes 8'h00..8'h1F, no host_last.
  - Response: host_ready=0 after the 32nd transfer; 32 load cycles with data_out == index; then done=1.
- PAD_TO_FULL=1, short program:
  - Stimulus: start, bytes 8'h25, 8'h61 with last.
  - Response: 32 load cycles; first two are 25, 61, the remaining 30 are 8'h00.
- Backpressure and ignored inputs:
  - Stimulus: host_valid toggled randomly during FILL; start pulsed mid-STREAM; host_valid asserted in DONE.
  - Response: only valid&&ready beats stored; stream unchanged; no extra writes; byte_count unchanged.
- Reset mid-STREAM:
  - Stimulus: assert reset at the 4th load cycle.
  - Response: load_out=0 on the next edge; state IDLE.
  - Follow-up: a new session (start + 1 byte 8'h3C with last, PAD_TO_FULL=0) streams exactly 1 byte, 8'h3C.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader.
// Holds the loader state encoding, the instruction byte layout
// ({opcode, addr}), and the HALT filler byte used to pad short programs.
package program_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StStream,
        StDone
    } loader_state_e;

    localparam int unsigned OpcodeWidth = 3;
    localparam int unsigned AddrWidth   = 5;
    localparam int unsigned ByteWidth   = OpcodeWidth + AddrWidth;

    localparam logic [OpcodeWidth-1:0] OpHalt   = 3'b000;
    // HALT to address 0: a CPU that runs into padding simply stops.
    localparam logic [ByteWidth-1:0]   HaltByte = {OpHalt, {AddrWidth{1'b0}}};

endpackage

// File: rtl/program_buffer.sv
// Program buffer: DEPTH x 8-bit storage for one loaded program.
// Ports:
//   clock   - write clock, rising edge
//   wr_en   - write strobe for wr_addr/wr_data
//   wr_addr - write address
//   wr_data - byte to store
//   rd_addr - asynchronous read address
//   rd_data - byte at rd_addr (combinational)
// Contents are deliberately not reset.
module program_buffer
    import program_loader_pkg::*;
#(
    parameter int unsigned  DEPTH    = 32,
    localparam int unsigned AddrBits = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 wr_en,
    input  logic [AddrBits-1:0]  wr_addr,
    input  logic [ByteWidth-1:0] wr_data,
    input  logic [AddrBits-1:0]  rd_addr,
    output logic [ByteWidth-1:0] rd_data
);

    logic [ByteWidth-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/program_loader.sv
// Program loader: collects a program byte stream from a host over a
// valid/ready handshake, then replays it to the CPU as one contiguous burst
// of Load-qualified bytes and raises done.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   start         - begin a session (honoured only in IDLE or DONE)
//   host_valid/host_data/host_last/host_ready - host byte handshake
//   load_out/data_out - CPU Load strobe and data_in byte (registered)
//   busy          - session in progress (FILL or STREAM)
//   done          - stream finished; held until start or reset
//   byte_count    - bytes accepted in the current session
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned          DEPTH       = 32,
    parameter bit                   PAD_TO_FULL = 1'b1,
    parameter logic [ByteWidth-1:0] PAD_BYTE    = HaltByte,
    localparam int unsigned         PtrWidth    = $clog2(DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 host_valid,
    input  logic [ByteWidth-1:0] host_data,
    input  logic                 host_last,
    output logic                 host_ready,
    output logic                 load_out,
    output logic [ByteWidth-1:0] data_out,
    output logic                 busy,
    output logic                 done,
    output logic [PtrWidth-1:0]  byte_count
);

    localparam int unsigned         AddrBits = $clog2(DEPTH);
    // Pointers carry one extra bit so that DEPTH itself is representable.
    localparam logic [PtrWidth-1:0] DepthVal = PtrWidth'(DEPTH);
    localparam logic [PtrWidth-1:0] PtrOne   = PtrWidth'(1);

    loader_state_e        state_q, state_d;
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrWidth-1:0]  count_q, count_d;
    logic                 load_q, load_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [ByteWidth-1:0] data_q, data_d;
    logic [ByteWidth-1:0] rd_data;
    logic [PtrWidth-1:0]  last_idx;
    logic                 wr_en;

    assign host_ready = (state_q == StFill) && (wr_ptr_q < DepthVal);
    assign wr_en      = host_valid && host_ready;
    // Index of the final streamed byte; count_q >= 1 whenever STREAM is entered.
    assign last_idx   = PAD_TO_FULL ? (DepthVal - PtrOne) : (count_q - PtrOne);

    program_buffer #(
        .DEPTH(DEPTH)
    ) u_buffer (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q[AddrBits-1:0]),
        .wr_data (host_data),
        .rd_addr (rd_ptr_q[AddrBits-1:0]),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        load_d   = 1'b0;
        data_d   = data_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StFill;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end
            end
            StFill: begin
                if (wr_en) begin
                    wr_ptr_d = wr_ptr_q + PtrOne;
                    count_d  = count_q + PtrOne;
                    // A full buffer ends the fill even without host_last.
                    if (host_last || (wr_ptr_q == DepthVal - PtrOne)) begin
                        state_d = StStream;
                    end
                end
            end
            StStream: begin
                data_d   = (rd_ptr_q < count_q) ? rd_data : PAD_BYTE;
                load_d   = 1'b1;
                rd_ptr_d = rd_ptr_q + PtrOne;
                if (rd_ptr_q == last_idx) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StFill) || (state_d == StStream);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            load_q   <= 1'b0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            load_q   <= load_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign load_out   = load_q;
    assign data_out   = data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign byte_count = count_q;

endmodule
